wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (regwr/rw/busW/fpoint) between two sources: the in-order pipeline writeback stage and a long-latency unit (mul/div/FP).
- The pipeline has priority. Long-latency results are buffered in a small FIFO and drain into idle writeback slots.
- A starvation counter asks the pipeline to stall for one bubble so a buffered result can retire.
- Sits between the Write stage register and the register file. WAW ordering is guaranteed by the issue scoreboard, not by this block.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive denied-pop cycles before stall_req is raised (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- pipe_regwr  in  1  pipeline writeback valid
- pipe_rw  in  5  pipeline destination register
- pipe_busW  in  32  pipeline write data
- pipe_fpoint  in  2  pipeline register-file select
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept (= !full)
- lu_rw  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- lu_fpoint  in  2  long-latency register-file select
- regwr  out  1  register-file write enable (registered)
- rw  out  5  register-file write address (registered)
- busW  out  32  register-file write data (registered)
- fpoint  out  2  register-file select (registered)
- stall_req  out  1  pipeline must insert a writeback bubble this cycle (registered)
- proto_err  out  1  sticky: pipe_regwr seen while stall_req=1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - regwr/rw/busW/fpoint/stall_req/proto_err = 0.
  - FIFO empty, counter = 0, state = IDLE.
  - lu_ready = 0 while rst_n=0; after reset lu_ready = !full.
- Reset mid-operation discards all FIFO contents.
- Push: lu_valid & lu_ready at edge N writes the entry. There is no same-cycle pass-through when full: ready depends on full only, even if a pop happens that cycle.
- Output selection, decided at cycle N, appears on outputs at N+1:
  1. pipe_regwr=1 → pipeline fields.
  2. Else FIFO non-empty → pop head.
  3. Else regwr=0, and rw/busW/fpoint = 0.
- Latency:
  - Pipeline path: 1 cycle.
  - FIFO path: minimum 2 cycles (push at N, pop at N+1, output at N+2).
- FIFO pointers wrap modulo DEPTH. Full/empty are tracked with an extra pointer bit. Simultaneous push and pop when non-full and non-empty leaves occupancy unchanged.
- States:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty, pipeline has priority.
  - STALL: stall_req=1.
- Transitions:
  - IDLE → PEND on push.
  - PEND → IDLE when the last entry pops with no push.
  - PEND, cycle where a pop is denied (pipe_regwr=1): counter++.
  - PEND, counter reaches STARVE_LIMIT → STALL next cycle, and stall_req=1.
  - STALL (one cycle): the pipeline guarantees pipe_regwr=0; the head pops; counter clears; next state is PEND or IDLE by occupancy.
- If pipe_regwr=1 during STALL:
  - The pipeline write still wins and no pop occurs.
  - proto_err sets and stays set until reset.
  - The block remains in STALL.
- Counter clears on any pop and while the FIFO is empty. Width is clog2(STARVE_LIMIT+1); it saturates and never wraps.

Optional Feature:
- WB_BYPASS_EN defined:
  - When the FIFO is empty, pipe_regwr=0 and lu_valid=1, the LU result goes straight to the output register (1-cycle latency) and is not pushed. lu_ready stays 1 in that case.
- Undefined: every LU result goes through the FIFO (2-cycle minimum).

Decomposition:
- Shared package wb_pkg:
  - wb_req_t struct {rw[4:0], data[31:0], fpoint[1:0]}
  - state enum {IDLE, PEND, STALL}
  - REG_W=5, DATA_W=32, FP_W=2
- One sub-module, wb_result_fifo: DEPTH-parameterised synchronous FIFO of wb_req_t with push/pop/full/empty.
- Arbitration, FSM and counter stay in the top.

Test Plan:
- Reset check: after reset, all outputs 0 and lu_ready=1. pipe_regwr=1, rw=5, busW=0xDEADBEEF, fpoint=1 → next cycle regwr=1, rw=5, busW=0xDEADBEEF, fpoint=1.
- LU path: lu_valid=1, rw=9, data=0x1234, pipeline idle → regwr=1, rw=9, busW=0x1234 two cycles later (one cycle with WB_BYPASS_EN).
- Contention: LU push of rw=3 while pipe_regwr=1 on three consecutive cycles → pipeline writes retire first; rw=3 written in the first cycle with pipe_regwr=0.
- Full: 4 LU pushes while pipe_regwr=1 continuously, DEPTH=4 → lu_ready=0 after the 4th push; a 5th lu_valid is not accepted.
- Starvation: FIFO holds 1 entry, pipe_regwr=1 for 8 cycles → stall_req=1 for exactly one cycle; with pipe_regwr=0 the entry is written and the counter clears.
- Protocol/reset: pipe_regwr=1 while stall_req=1 → pipeline data written and proto_err=1 sticky. rst_n=0 with 2 entries buffered → FIFO empty, no later LU writes, proto_err=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter:
// write request bundle, arbiter FSM states and field widths.
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int FP_W   = 2;

    typedef struct packed {
        logic [REG_W-1:0]  rw;
        logic [DATA_W-1:0] data;
        logic [FP_W-1:0]   fpoint;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of long-latency write requests.
// Ports: clk_i, rst_ni (sync, active low), push_i/data_i, pop_i/head_o,
//        full_o, empty_o, count_o (occupancy).
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  wb_req_t                  data_i,
    input  logic                     pop_i,
    output wb_req_t                  head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t     mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_push, do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback
// stage (priority) and a buffered long-latency unit; a starvation
// counter requests a one-cycle writeback bubble so buffered results
// retire. Optional macro WB_BYPASS_EN: an LU result arriving while the
// FIFO is empty and the pipeline is idle goes straight to the output.
// Ports: clk, rst_n (sync, active low); pipe_* writeback request;
//        lu_valid/lu_ready + lu_* LU result; regwr/rw/busW/fpoint
//        registered write port; stall_req registered; proto_err sticky.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_regwr,
    input  logic [REG_W-1:0]  pipe_rw,
    input  logic [DATA_W-1:0] pipe_busW,
    input  logic [FP_W-1:0]   pipe_fpoint,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_W-1:0]  lu_rw,
    input  logic [DATA_W-1:0] lu_data,
    input  logic [FP_W-1:0]   lu_fpoint,
    output logic              regwr,
    output logic [REG_W-1:0]  rw,
    output logic [DATA_W-1:0] busW,
    output logic [FP_W-1:0]   fpoint,
    output logic              stall_req,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    wb_req_t          pipe_req, lu_req, head;
    wb_req_t          out_q, out_d;
    logic             regwr_q, regwr_d;
    logic             stall_q, stall_d;
    logic             proto_q, proto_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, empty, push, pop, bypass, last_pop;
    logic [CW-1:0]    count;

    assign pipe_req = '{rw: pipe_rw, data: pipe_busW, fpoint: pipe_fpoint};
    assign lu_req   = '{rw: lu_rw, data: lu_data, fpoint: lu_fpoint};

    // Ready depends on full only: no pass-through on a full FIFO.
    assign lu_ready = rst_n && !full;

`ifdef WB_BYPASS_EN
    assign bypass = rst_n && empty && !pipe_regwr && lu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push     = lu_valid && lu_ready && !bypass;
    assign pop      = !pipe_regwr && !empty;
    assign last_pop = pop && !push && (count == CW'(1));

    wb_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (push),
        .data_i (lu_req),
        .pop_i  (pop),
        .head_o (head),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );

    always_comb begin
        regwr_d = 1'b0;
        out_d   = '0;
        if (pipe_regwr) begin
            regwr_d = 1'b1;
            out_d   = pipe_req;
        end else if (!empty) begin
            regwr_d = 1'b1;
            out_d   = head;
        end else if (bypass) begin
            regwr_d = 1'b1;
            out_d   = lu_req;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        proto_d = proto_q;

        // Counts denied pops only; saturates at the limit.
        if (pop || empty) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (stall_q && pipe_regwr) proto_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (push) state_d = PEND;
            end
            PEND: begin
                if (cnt_d == LIMIT)  state_d = STALL;
                else if (last_pop)   state_d = IDLE;
            end
            STALL: begin
                // A misbehaving pipeline keeps the bubble request up.
                if (!pipe_regwr) state_d = last_pop ? IDLE : PEND;
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d == STALL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            proto_q <= 1'b0;
            regwr_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            proto_q <= proto_d;
            regwr_q <= regwr_d;
            out_q   <= out_d;
        end
    end

    assign regwr     = regwr_q;
    assign rw        = out_q.rw;
    assign busW      = out_q.data;
    assign fpoint    = out_q.fpoint;
    assign stall_req = stall_q;
    assign proto_err = proto_q;

endmodule
